// File: rtl/map_checkpoint_ctrl_pkg.sv
// map_checkpoint_ctrl_pkg: map-table row types and checkpoint sizing shared by the checkpoint controller
package map_checkpoint_ctrl_pkg;
  localparam int NUM_GEN_REG = 8;
  localparam int NUM_PHYS_REG = 16;
  localparam int PR_W = $clog2(NUM_PHYS_REG);
  localparam int NUM_CKPT = 4;
  localparam int CKPT_W = $clog2(NUM_CKPT);
  typedef logic [PR_W:0] PHYS_REG;
  typedef logic [$clog2(NUM_GEN_REG)-1:0] GEN_REG;
  typedef logic [CKPT_W-1:0] CKPT_ID;
  typedef struct packed {
    PHYS_REG phys_tag;
  } MAP_ROW_T;
  typedef MAP_ROW_T [NUM_GEN_REG-1:0] MAP_IMG_T;
endpackage

// File: rtl/map_cdb_merge.sv
// map_cdb_merge: folds a CDB broadcast into a map-table image so stored copies keep current ready bits
module map_cdb_merge
  import map_checkpoint_ctrl_pkg::*;
(
  input  MAP_IMG_T img,
  input  logic     cdb_en,
  input  PHYS_REG  cdb_tag,
  output MAP_IMG_T merged
);
  genvar r;
  generate
    for (r = 0; r < NUM_GEN_REG; r++) begin : g_row
      assign merged[r].phys_tag = (cdb_en && img[r].phys_tag[PR_W-1:0] == cdb_tag[PR_W-1:0])
                                  ? cdb_tag : img[r].phys_tag;
    end
  endgenerate
endmodule

// File: rtl/map_checkpoint_ctrl.sv
// map_checkpoint_ctrl: per-branch map-table snapshots with in-order release and mispredict rollback
module map_checkpoint_ctrl
  import map_checkpoint_ctrl_pkg::*;
#(
  parameter int NUM_CKPT = map_checkpoint_ctrl_pkg::NUM_CKPT,
  parameter int CKPT_W = $clog2(NUM_CKPT),
  parameter int CNT_W = $clog2(NUM_CKPT + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  MAP_IMG_T            map_table_in,
  input  logic                branch_dispatch,
  output logic                ckpt_full,
  output logic [CKPT_W-1:0]   ckpt_id,
  input  logic                branch_resolve,
  input  logic [CKPT_W-1:0]   resolve_id,
  input  logic                resolve_mispredict,
  input  logic                CDB_en,
  input  PHYS_REG             CDB_tag_in,
  output logic                branch_incorrect,
  output MAP_IMG_T            map_check_point,
  output logic [NUM_CKPT-1:0] flush_mask,
  output logic [CNT_W-1:0]    ckpt_count
);
  MAP_IMG_T ckpt [NUM_CKPT];
  MAP_IMG_T merged [NUM_CKPT];
  MAP_IMG_T in_m, out_m, restore_q;
  logic [NUM_CKPT-1:0] valid, valid_n, fmask, flush_q;
  logic [CKPT_W-1:0] head, tail, kd, head_n, tail_n;
  logic [CNT_W-1:0] count, count_n;
  logic incorrect_q, mis, good, alloc, retire;
  genvar i;
  generate
    for (i = 0; i < NUM_CKPT; i++) begin : g_slot
      logic [CKPT_W-1:0] d;
      map_cdb_merge u_m (.img(ckpt[i]), .cdb_en(CDB_en), .cdb_tag(CDB_tag_in), .merged(merged[i]));
      // distance from head decides membership in the squashed range, so a full ring (head==tail) works
      assign d = CKPT_W'(i) - head;
      assign fmask[i] = mis && d >= kd && CNT_W'(d) < count;
    end
  endgenerate
  map_cdb_merge u_in (.img(map_table_in), .cdb_en(CDB_en), .cdb_tag(CDB_tag_in), .merged(in_m));
  map_cdb_merge u_out (.img(restore_q), .cdb_en(CDB_en), .cdb_tag(CDB_tag_in), .merged(out_m));
  always_comb begin
    ckpt_full = count == CNT_W'(NUM_CKPT);
    mis = branch_resolve && resolve_mispredict && valid[resolve_id];
    good = branch_resolve && !resolve_mispredict && valid[resolve_id];
    alloc = branch_dispatch && !ckpt_full && !mis;
    retire = !mis && count != '0 && !valid[head];
    kd = resolve_id - head;
    valid_n = (valid & ~fmask & ~(good ? NUM_CKPT'(1) << resolve_id : '0))
              | (alloc ? NUM_CKPT'(1) << tail : '0);
    head_n = head + CKPT_W'(retire);
    tail_n = mis ? resolve_id : tail + CKPT_W'(alloc);
    count_n = mis ? CNT_W'(kd) : count + CNT_W'(alloc) - CNT_W'(retire);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NUM_CKPT; j++) ckpt[j] <= '0;
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      restore_q <= '0;
      incorrect_q <= 1'b0;
      flush_q <= '0;
    end else begin
      for (int j = 0; j < NUM_CKPT; j++) if (valid[j]) ckpt[j] <= merged[j];
      if (alloc) ckpt[tail] <= in_m;
      if (mis) restore_q <= merged[resolve_id];
      incorrect_q <= mis;
      flush_q <= fmask;
      valid <= valid_n;
      head <= head_n;
      tail <= tail_n;
      count <= count_n;
    end
  end
  assign ckpt_id = tail;
  assign ckpt_count = count;
  assign branch_incorrect = incorrect_q;
  assign flush_mask = flush_q;
  // the map table ignores the CDB during a restore, so the restore image carries it instead
  assign map_check_point = incorrect_q ? out_m : restore_q;
endmodule
